path_count_accumulator: RTL and testbench
=========================================

Name: path_count_accumulator

Overview:
- Forward-pass DAG path counter. Consumes the topologically sorted node stream and walks each node's out-edges through the adjacency map query/reply port.
- Accumulates per-node path counts in a local RAM and reports the number of start→end paths.
- Generalised with up to two mandatory waypoint nodes, tracked as 2^NUM_WAYPOINTS count channels, plus selectable saturate/wrap arithmetic.
- Sits after topological_sort and feeds tap_encoder.

Parameters:
- MAX_NODES, 1024, node index space; NODE_WIDTH = $clog2(MAX_NODES).
- COUNT_WIDTH, 48, width of each path-count channel.
- NUM_WAYPOINTS, 0, number of waypoint nodes (0..2); CHANNELS = 2**NUM_WAYPOINTS.
- FIFO_DEPTH, 64, depth of the sorted-node input buffer (power of 2).
- SATURATE, 1, 1 = clamp at all-ones, 0 = modulo 2^COUNT_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- node_idx_cnt  in  NODE_WIDTH  number of valid node indices (RAM init range).
- start_node, end_node  in  NODE_WIDTH each  path endpoints.
- waypoint_nodes  in  2*NODE_WIDTH  waypoint k at bits [k*NODE_WIDTH +: NODE_WIDTH]; bits for k ≥ NUM_WAYPOINTS are ignored.
- start_end_nodes_valid  in  1  level; endpoints and waypoints are stable while high.
- sorted_valid, sorted_node  in  1, NODE_WIDTH  sorted node stream; no backpressure.
- sorted_done  in  1  level; the stream is complete.
- query_ready  in  1; query_valid  out  1; query_data  out  NODE_WIDTH  source node query.
- reply_valid, reply_last, reply_no_edges_found  in  1 each; reply_data  in  NODE_WIDTH  destination nodes.
- reply_ready  out  1.
- result_valid  out  1  single-cycle pulse.
- result_data  out  COUNT_WIDTH  count[end_node][CHANNELS-1]; held after the pulse.
- result_overflow  out  1  sticky; some addition exceeded COUNT_WIDTH.
- fifo_overflow  out  1  sticky; sorted_valid arrived while the buffer was full (node dropped).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM returns to IDLE; FIFO is emptied.
  - All outputs go to 0, including result_data and both sticky flags.
  - Reset mid-operation abandons the current query; reply beats that arrive later are ignored (reply_ready=0).
- Input FIFO:
  - Captures sorted_node on every sorted_valid, in every state except reset.
  - Push while full: the node is dropped and fifo_overflow is set.
- Count RAM: MAX_NODES words of CHANNELS*COUNT_WIDTH bits; 1-cycle read latency.
- Waypoint mask: wmask(n) bit k = (n == waypoint k). Channel c holds paths whose visited-waypoint set equals c.
- FSM states and transitions:
  - IDLE: wait for start_end_nodes_valid → CLEAR.
  - CLEAR: write zero to words 0..node_idx_cnt-1, one per cycle. Then write word start_node with channel wmask(start_node) = 1, all other channels 0 → FETCH.
  - FETCH:
    - FIFO non-empty: pop the node as src and read count[src] → LOAD.
    - FIFO empty with sorted_done=1 → FINISH.
  - LOAD: latch src_counts. If all channels are zero → FETCH (no query issued); otherwise → QUERY.
  - QUERY: assert query_valid with query_data=src, held until query_ready is sampled high → REPLY.
  - REPLY:
    - reply_ready is high only when no read-modify-write is in flight.
    - A beat with reply_no_edges_found → FETCH.
    - Otherwise, for each channel c: count[dst][c | wmask(dst)] += src_counts[c].
    - This is a 2-cycle read-modify-write, so the peak rate is one beat every 2 cycles.
    - A beat with reply_last returns to FETCH once its write commits.
  - FINISH: read count[end_node]. Next cycle: result_data = channel CHANNELS-1, pulse result_valid → DONE.
  - DONE: hold outputs until reset.
- Arithmetic:
  - An addition with carry-out sets result_overflow.
  - SATURATE=1 writes all-ones; SATURATE=0 keeps the low COUNT_WIDTH bits.
- Nodes popped before start_node in sort order have zero counts and are skipped.
- end_node == start_node: the result is 1 if the start node's waypoint mask equals CHANNELS-1, else 0.
- Repeated dst within one reply: the read-modify-writes are serialized, so every beat accumulates.

Test Plan:
- Diamond: edges 0→1, 0→2, 1→3, 2→3; start=0, end=3, NUM_WAYPOINTS=0; sorted stream 0,1,2,3 → result_valid pulse, result_data=2, both flags 0.
- Same diamond, NUM_WAYPOINTS=1, waypoint=1 → result_data=1. With waypoints {1,2} (NUM_WAYPOINTS=2) → result_data=0.
- Five diamonds chained (32 paths), COUNT_WIDTH=4:
  - SATURATE=1 → result_data=15, result_overflow=1.
  - SATURATE=0 → result_data=0, result_overflow=1.
- Node 4 has no out-edges and is reached from 0: reply_no_edges_found on its query → FSM returns to FETCH and the result is unaffected. Unreachable node 5 issues no query (query_valid never asserted with data=5).
- FIFO_DEPTH=4 and a burst of 6 sorted_valid while the FSM is held in CLEAR → fifo_overflow=1, 2 nodes dropped.
- query_ready held low 10 cycles → query_valid and query_data stay stable throughout.
- rst_n pulsed low during REPLY → all outputs are 0 next cycle, reply_ready=0. A re-run on the diamond then yields result_data=2.

Source files
------------

// File: rtl/path_count_accumulator.sv
// path_count_accumulator
//   Forward-pass DAG path counter. Sorted nodes are buffered in a small FIFO.
//   Each popped node with a non-zero count queries the adjacency map. Every
//   returned destination gets a read-modify-write of its count word. Up to two
//   waypoint nodes split each count into 2**NUM_WAYPOINTS channels. Channel c
//   counts paths whose set of visited waypoints equals c.
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   node_idx_cnt           number of count words cleared before a run
//   start_node, end_node   path endpoints
//   waypoint_nodes         waypoint k at [k*NODE_WIDTH +: NODE_WIDTH]
//   start_end_nodes_valid  starts a run from IDLE
//   sorted_valid/_node     topologically sorted node stream (no backpressure)
//   sorted_done            stream complete
//   query_*                source-node query to the adjacency map
//   reply_*                destination beats back from the adjacency map
//   result_valid/_data     one-cycle pulse, data = paths visiting all waypoints
//   result_overflow        sticky, some addition carried out
//   fifo_overflow          sticky, a sorted node was dropped on a full FIFO
module path_count_accumulator #(
    parameter int MAX_NODES     = 1024,
    parameter int COUNT_WIDTH   = 48,
    parameter int NUM_WAYPOINTS = 0,
    parameter int FIFO_DEPTH    = 64,
    parameter int SATURATE      = 1,
    localparam int NODE_WIDTH   = $clog2(MAX_NODES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NODE_WIDTH-1:0]   node_idx_cnt,
    input  logic [NODE_WIDTH-1:0]   start_node,
    input  logic [NODE_WIDTH-1:0]   end_node,
    input  logic [2*NODE_WIDTH-1:0] waypoint_nodes,
    input  logic                    start_end_nodes_valid,
    input  logic                    sorted_valid,
    input  logic [NODE_WIDTH-1:0]   sorted_node,
    input  logic                    sorted_done,
    input  logic                    query_ready,
    output logic                    query_valid,
    output logic [NODE_WIDTH-1:0]   query_data,
    input  logic                    reply_valid,
    input  logic                    reply_last,
    input  logic                    reply_no_edges_found,
    input  logic [NODE_WIDTH-1:0]   reply_data,
    output logic                    reply_ready,
    output logic                    result_valid,
    output logic [COUNT_WIDTH-1:0]  result_data,
    output logic                    result_overflow,
    output logic                    fifo_overflow
);
    localparam int CHANNELS = 2 ** NUM_WAYPOINTS;
    localparam int FAW      = $clog2(FIFO_DEPTH);

    typedef logic [CHANNELS-1:0][COUNT_WIDTH-1:0] word_t;

    // RESULT sits between FINISH and DONE to absorb the 1-cycle RAM read latency.
    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_QUERY, S_REPLY, S_FINISH, S_RESULT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [FAW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NODE_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [NODE_WIDTH-1:0]   clr_q, clr_d, src_q, src_d, dst_q, dst_d;
    word_t                   srcc_q, srcc_d, ram_rdata_q, ram_wdata;
    word_t                   ram [MAX_NODES];
    logic                    rmw_q, rmw_d, last_q, last_d;
    logic [COUNT_WIDTH-1:0]  res_q, res_d;
    logic                    resv_q, resv_d, ovf_q, ovf_d, fovf_q, fovf_d;
    logic                    ram_we;
    logic [NODE_WIDTH-1:0]   ram_waddr, ram_raddr;
    logic                    fifo_full, fifo_empty, push;
    logic [NODE_WIDTH-1:0]   fifo_head;
    logic                    unused_wp;

    // Waypoint bits beyond NUM_WAYPOINTS are intentionally ignored.
    assign unused_wp = ^waypoint_nodes;

    function automatic logic [1:0] wmask(input logic [NODE_WIDTH-1:0] n);
        logic [1:0] m;
        m = '0;
        for (int k = 0; k < 2; k++)
            if (k < NUM_WAYPOINTS && n == waypoint_nodes[k*NODE_WIDTH +: NODE_WIDTH])
                m[k] = 1'b1;
        return m;
    endfunction

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[FAW] != rptr_q[FAW]) && (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]);
    assign push       = rst_n && sorted_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rptr_q[FAW-1:0]];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q[FAW-1:0]] <= sorted_node;
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        ram_rdata_q <= ram[ram_raddr];
    end

    always_comb begin
        logic [1:0]             m;
        logic [COUNT_WIDTH:0]   sum;
        word_t                  acc;
        m         = '0;
        sum       = '0;
        acc       = '0;
        state_d   = state_q;
        wptr_d    = wptr_q + {{FAW{1'b0}}, push};
        rptr_d    = rptr_q;
        clr_d     = clr_q;
        src_d     = src_q;
        dst_d     = dst_q;
        srcc_d    = srcc_q;
        rmw_d     = 1'b0;
        last_d    = last_q;
        res_d     = res_q;
        resv_d    = 1'b0;
        ovf_d     = ovf_q;
        fovf_d    = fovf_q | (sorted_valid & fifo_full);
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;

        case (state_q)
            S_IDLE: begin
                clr_d = '0;
                if (start_end_nodes_valid) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                ram_we = 1'b1;
                if (clr_q == node_idx_cnt) begin
                    // Seed the start node in the channel of its own waypoint set.
                    m         = wmask(start_node);
                    ram_waddr = start_node;
                    for (int c = 0; c < CHANNELS; c++)
                        if (c == int'(m)) ram_wdata[c] = COUNT_WIDTH'(1);
                    state_d = S_FETCH;
                end else begin
                    ram_waddr = clr_q;
                    clr_d     = clr_q + {{(NODE_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    ram_raddr = fifo_head;
                    src_d     = fifo_head;
                    rptr_d    = rptr_q + {{FAW{1'b0}}, 1'b1};
                    state_d   = S_LOAD;
                end else if (sorted_done) begin
                    state_d = S_FINISH;
                end
            end
            S_LOAD: begin
                srcc_d  = ram_rdata_q;
                // Unreached nodes contribute nothing, so skip the query entirely.
                state_d = (ram_rdata_q == '0) ? S_FETCH : S_QUERY;
            end
            S_QUERY: begin
                if (query_ready) state_d = S_REPLY;
            end
            S_REPLY: begin
                if (rmw_q) begin
                    // Second half of the RMW: old dst word is on ram_rdata_q.
                    m   = wmask(dst_q);
                    acc = ram_rdata_q;
                    for (int c = 0; c < CHANNELS; c++)
                        for (int t = 0; t < CHANNELS; t++)
                            if (t == (c | int'(m))) begin
                                sum = {1'b0, acc[t]} + {1'b0, srcc_q[c]};
                                if (sum[COUNT_WIDTH]) begin
                                    ovf_d  = 1'b1;
                                    acc[t] = (SATURATE != 0) ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
                                end else begin
                                    acc[t] = sum[COUNT_WIDTH-1:0];
                                end
                            end
                    ram_we    = 1'b1;
                    ram_waddr = dst_q;
                    ram_wdata = acc;
                    if (last_q) state_d = S_FETCH;
                end else if (reply_valid) begin
                    if (reply_no_edges_found) begin
                        state_d = S_FETCH;
                    end else begin
                        ram_raddr = reply_data;
                        dst_d     = reply_data;
                        last_d    = reply_last;
                        rmw_d     = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                ram_raddr = end_node;
                state_d   = S_RESULT;
            end
            S_RESULT: begin
                res_d   = ram_rdata_q[CHANNELS-1];
                resv_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            clr_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            srcc_q  <= '0;
            rmw_q   <= 1'b0;
            last_q  <= 1'b0;
            res_q   <= '0;
            resv_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            clr_q   <= clr_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            srcc_q  <= srcc_d;
            rmw_q   <= rmw_d;
            last_q  <= last_d;
            res_q   <= res_d;
            resv_q  <= resv_d;
            ovf_q   <= ovf_d;
            fovf_q  <= fovf_d;
        end
    end

    assign query_valid     = (state_q == S_QUERY);
    assign query_data      = src_q;
    // A beat is only taken once the previous RMW has committed.
    assign reply_ready     = (state_q == S_REPLY) && !rmw_q;
    assign result_valid    = resv_q;
    assign result_data     = res_q;
    assign result_overflow = ovf_q;
    assign fifo_overflow   = fovf_q;
endmodule

// File: tb/tb_path_count_accumulator.sv
// Bench for path_count_accumulator. Five instances share one stimulus stream:
//   0: no waypoints, saturating   1: one waypoint   2: two waypoints
//   3: no waypoints, wrapping     4: no waypoints, FIFO depth 4
// Each instance has its own adjacency responder driven from a shared edge table.
module tb_path_count_accumulator;
    localparam int NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sev, sv, sd, qr_hold;
    logic [4:0] nic, sn, en, snode;
    logic [9:0] wp;

    int         adj_n [32];
    logic [4:0] adj_d [32][4];

    logic [NI-1:0]       a_qv, a_rr, a_rv, a_rovf, a_fovf, a_q4, a_q5;
    logic [NI-1:0][4:0]  a_qd;
    logic [NI-1:0][3:0]  a_rd;
    logic [NI-1:0][7:0]  a_pc;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int NWP = (g == 1) ? 1 : (g == 2) ? 2 : 0;
        localparam int SAT = (g == 3) ? 0 : 1;
        localparam int FD  = (g == 4) ? 4 : 16;
        logic       qr, rvl, rlast, rne, rrdy, qvl, resv, rovf_l, fovf_l;
        logic [4:0] qdat, rdat, src;
        logic [3:0] resd;
        logic       busy, sq4, sq5;
        logic [7:0] pc;
        int         idx;

        path_count_accumulator #(
            .MAX_NODES(32), .COUNT_WIDTH(4), .NUM_WAYPOINTS(NWP),
            .FIFO_DEPTH(FD), .SATURATE(SAT)
        ) dut (
            .clk(clk), .rst_n(rst_n), .node_idx_cnt(nic), .start_node(sn), .end_node(en),
            .waypoint_nodes(wp), .start_end_nodes_valid(sev), .sorted_valid(sv),
            .sorted_node(snode), .sorted_done(sd), .query_ready(qr), .query_valid(qvl),
            .query_data(qdat), .reply_valid(rvl), .reply_last(rlast),
            .reply_no_edges_found(rne), .reply_data(rdat), .reply_ready(rrdy),
            .result_valid(resv), .result_data(resd), .result_overflow(rovf_l),
            .fifo_overflow(fovf_l)
        );

        always_comb begin
            qr    = !busy && !qr_hold;
            rvl   = busy;
            rne   = (adj_n[src] == 0);
            rlast = rne || (idx == adj_n[src] - 1);
            rdat  = adj_d[src][idx];
        end

        always @(posedge clk) begin
            if (!rst_n) begin
                busy <= 1'b0; idx <= 0; src <= '0; pc <= '0; sq4 <= 1'b0; sq5 <= 1'b0;
            end else begin
                if (resv) pc <= pc + 8'd1;
                if (qvl && qdat == 5'd4) sq4 <= 1'b1;
                if (qvl && qdat == 5'd5) sq5 <= 1'b1;
                if (!busy && qvl && qr) begin
                    busy <= 1'b1; src <= qdat; idx <= 0;
                end else if (busy && rrdy) begin
                    if (rlast) busy <= 1'b0;
                    else idx <= idx + 1;
                end
            end
        end

        assign a_qv[g] = qvl;  assign a_qd[g] = qdat;  assign a_rr[g] = rrdy;
        assign a_rv[g] = resv; assign a_rd[g] = resd;  assign a_rovf[g] = rovf_l;
        assign a_fovf[g] = fovf_l; assign a_pc[g] = pc; assign a_q4[g] = sq4;
        assign a_q5[g] = sq5;
    end

    task automatic clear_graph();
        for (int i = 0; i < 32; i++) begin
            adj_n[i] = 0;
            for (int k = 0; k < 4; k++) adj_d[i][k] = '0;
        end
    endtask

    task automatic add_edge(input int s, input int d);
        adj_d[s][adj_n[s]] = 5'(d);
        adj_n[s] = adj_n[s] + 1;
    endtask

    task automatic diamond();
        add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sev = 1'b0; sv = 1'b0; sd = 1'b0; qr_hold = 1'b0; snode = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Stream is always nodes 0..nn-1, which is a valid topological order here.
    task automatic start_run(input int s, input int e, input int nn);
        sn = 5'(s); en = 5'(e); sev = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < nn; i++) begin
            sv = 1'b1; snode = 5'(i);
            @(posedge clk); #1;
        end
        sv = 1'b0; sd = 1'b1;
    endtask

    function automatic bit all_done();
        for (int g = 0; g < NI; g++) if (a_pc[g] == 8'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!all_done() && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        n_checks++;
        if (!all_done()) begin
            n_fail++;
            $display("FAIL %s_timeout pulses=%h required all nonzero", tag, a_pc);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (a_qv !== '0)   begin n_fail++; $display("FAIL reset_query_valid got %b want 0", a_qv); end
        n_checks++; if (a_rr !== '0)   begin n_fail++; $display("FAIL reset_reply_ready got %b want 0", a_rr); end
        n_checks++; if (a_rv !== '0)   begin n_fail++; $display("FAIL reset_result_valid got %b want 0", a_rv); end
        n_checks++; if (a_rd !== '0)   begin n_fail++; $display("FAIL reset_result_data got %h want 0", a_rd); end
        n_checks++; if (a_rovf !== '0) begin n_fail++; $display("FAIL reset_result_ovf got %b want 0", a_rovf); end
        n_checks++; if (a_fovf !== '0) begin n_fail++; $display("FAIL reset_fifo_ovf got %b want 0", a_fovf); end
    endtask

    // Diamond plus leaf 4 (reached from 0, no out-edges) and unreachable 5.
    task automatic test_diamond();
        clear_graph(); diamond(); add_edge(0, 4);
        wp = {5'd2, 5'd1};
        do_reset(); start_run(0, 3, 6); wait_done("diamond");
        n_checks++; if (a_rd[0] !== 4'd2) begin n_fail++; $display("FAIL diamond_nw0 got %0d want 2", a_rd[0]); end
        n_checks++; if (a_pc[0] !== 8'd1) begin n_fail++; $display("FAIL diamond_pulses got %0d want 1", a_pc[0]); end
        n_checks++; if (a_rovf[0] !== 1'b0) begin n_fail++; $display("FAIL diamond_rovf got %b want 0", a_rovf[0]); end
        n_checks++; if (a_fovf[0] !== 1'b0) begin n_fail++; $display("FAIL diamond_fovf got %b want 0", a_fovf[0]); end
        n_checks++; if (a_q4[0] !== 1'b1) begin n_fail++; $display("FAIL leaf_queried got %b want 1", a_q4[0]); end
        n_checks++; if (a_q5[0] !== 1'b0) begin n_fail++; $display("FAIL unreachable_queried got %b want 0", a_q5[0]); end
        n_checks++; if (a_rd[1] !== 4'd1) begin n_fail++; $display("FAIL diamond_wp1 got %0d want 1", a_rd[1]); end
        n_checks++; if (a_rd[2] !== 4'd0) begin n_fail++; $display("FAIL diamond_wp12 got %0d want 0", a_rd[2]); end
        n_checks++; if (a_rd[3] !== 4'd2) begin n_fail++; $display("FAIL diamond_wrap got %0d want 2", a_rd[3]); end
    endtask

    task automatic test_fifo_overflow();
        clear_graph(); diamond(); add_edge(0, 4);
        wp = '0;
        do_reset(); start_run(0, 3, 6); wait_done("fifo");
        n_checks++; if (a_fovf[4] !== 1'b1) begin n_fail++; $display("FAIL fifo_ovf_flag got %b want 1", a_fovf[4]); end
        n_checks++; if (a_q4[4] !== 1'b0) begin n_fail++; $display("FAIL fifo_dropped_node4 got %b want 0", a_q4[4]); end
        n_checks++; if (a_rd[4] !== 4'd2) begin n_fail++; $display("FAIL fifo_result got %0d want 2", a_rd[4]); end
        n_checks++; if (a_fovf[0] !== 1'b0) begin n_fail++; $display("FAIL fifo_deep_no_ovf got %b want 0", a_fovf[0]); end
    endtask

    task automatic test_waypoints();
        clear_graph(); diamond();
        wp = {5'd3, 5'd1};
        do_reset(); start_run(0, 3, 4); wait_done("wp13");
        n_checks++; if (a_rd[2] !== 4'd1) begin n_fail++; $display("FAIL wp13 got %0d want 1", a_rd[2]); end
        n_checks++; if (a_rd[1] !== 4'd1) begin n_fail++; $display("FAIL wp1_only got %0d want 1", a_rd[1]); end
    endtask

    task automatic test_start_is_end();
        clear_graph(); diamond();
        wp = {5'd1, 5'd0};
        do_reset(); start_run(0, 0, 4); wait_done("start_end");
        n_checks++; if (a_rd[0] !== 4'd1) begin n_fail++; $display("FAIL se_nw0 got %0d want 1", a_rd[0]); end
        n_checks++; if (a_rd[1] !== 4'd1) begin n_fail++; $display("FAIL se_nw1 got %0d want 1", a_rd[1]); end
        n_checks++; if (a_rd[2] !== 4'd0) begin n_fail++; $display("FAIL se_nw2 got %0d want 0", a_rd[2]); end
    endtask

    // Five chained diamonds give 32 paths, beyond a 4-bit count.
    task automatic test_chain();
        clear_graph();
        for (int i = 0; i < 5; i++) begin
            add_edge(3*i, 3*i+1); add_edge(3*i, 3*i+2);
            add_edge(3*i+1, 3*i+3); add_edge(3*i+2, 3*i+3);
        end
        wp = '0;
        do_reset(); start_run(0, 15, 16); wait_done("chain");
        n_checks++; if (a_rd[0] !== 4'd15) begin n_fail++; $display("FAIL chain_sat got %0d want 15", a_rd[0]); end
        n_checks++; if (a_rovf[0] !== 1'b1) begin n_fail++; $display("FAIL chain_sat_ovf got %b want 1", a_rovf[0]); end
        n_checks++; if (a_rd[3] !== 4'd0) begin n_fail++; $display("FAIL chain_wrap got %0d want 0", a_rd[3]); end
        n_checks++; if (a_rovf[3] !== 1'b1) begin n_fail++; $display("FAIL chain_wrap_ovf got %b want 1", a_rovf[3]); end
    endtask

    task automatic test_dup_dst();
        clear_graph(); add_edge(0, 1); add_edge(0, 1); add_edge(0, 2);
        add_edge(1, 3); add_edge(2, 3);
        wp = '0;
        do_reset(); start_run(0, 3, 4); wait_done("dup");
        n_checks++; if (a_rd[0] !== 4'd3) begin n_fail++; $display("FAIL dup_dst got %0d want 3", a_rd[0]); end
    endtask

    task automatic test_query_stall();
        int cyc = 0;
        logic [4:0] cap;
        clear_graph(); diamond(); wp = '0;
        do_reset(); qr_hold = 1'b1; start_run(0, 3, 4);
        while (a_qv[0] !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
        cap = a_qd[0];
        n_checks++; if (a_qv[0] !== 1'b1 || cap !== 5'd0) begin n_fail++; $display("FAIL stall_first_query valid=%b data=%0d want 1/0", a_qv[0], cap); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (a_qv[0] !== 1'b1 || a_qd[0] !== cap) begin
                n_fail++; $display("FAIL stall_hold cycle %0d valid=%b data=%0d want 1/%0d", i, a_qv[0], a_qd[0], cap);
            end
        end
        qr_hold = 1'b0;
        wait_done("stall");
        n_checks++; if (a_rd[0] !== 4'd2) begin n_fail++; $display("FAIL stall_result got %0d want 2", a_rd[0]); end
    endtask

    task automatic test_reset_in_reply();
        int cyc = 0;
        clear_graph(); diamond(); wp = '0;
        do_reset(); start_run(0, 3, 4);
        while (a_rr[0] !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (a_rr[0] !== 1'b1) begin n_fail++; $display("FAIL rr_reach_reply got %b want 1", a_rr[0]); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (a_rr !== '0) begin n_fail++; $display("FAIL rr_reply_ready got %b want 0", a_rr); end
        n_checks++; if (a_qv !== '0) begin n_fail++; $display("FAIL rr_query_valid got %b want 0", a_qv); end
        n_checks++; if (a_rd !== '0 || a_rv !== '0) begin n_fail++; $display("FAIL rr_result got %h/%b want 0", a_rd, a_rv); end
        n_checks++; if (a_rovf !== '0 || a_fovf !== '0) begin n_fail++; $display("FAIL rr_flags got %b/%b want 0", a_rovf, a_fovf); end
        rst_n = 1'b1; sev = 1'b0; sv = 1'b0; sd = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (a_rr[0] !== 1'b0) begin n_fail++; $display("FAIL rr_idle_ready got %b want 0", a_rr[0]); end
        do_reset(); start_run(0, 3, 4); wait_done("rerun");
        n_checks++; if (a_rd[0] !== 4'd2) begin n_fail++; $display("FAIL rerun_result got %0d want 2", a_rd[0]); end
    endtask

    initial begin
        rst_n = 1'b0; sev = 1'b0; sv = 1'b0; sd = 1'b0; qr_hold = 1'b0;
        nic = 5'd31; sn = '0; en = '0; snode = '0; wp = '0;
        clear_graph();
        test_reset();
        test_diamond();
        test_fifo_overflow();
        test_waypoints();
        test_start_is_end();
        test_chain();
        test_dup_dst();
        test_query_stall();
        test_reset_in_reply();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
